// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for seven-segment display blocks.
//   scan_state_t : scan FSM states, visited SHOW0 -> BLANK0 -> SHOW1 -> BLANK1.
//   SEG_BLANK    : active-low cathode pattern with every segment off.
//   HEX_SEG      : hex digit to active-low segment table, bit6=a ... bit0=g.
//   hex_to_seg   : table lookup helper.
package seg_pkg;

  typedef enum logic [1:0] {
    SHOW0  = 2'd0,
    BLANK0 = 2'd1,
    SHOW1  = 2'd2,
    BLANK1 = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low: a 0 lights the segment. Order is {a,b,c,d,e,f,g}.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    return HEX_SEG[value];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex to seven-segment decoder.
//   value : 4-bit hex digit in.
//   seg   : 7-bit active-low segments out, bit6=a ... bit0=g.
module seg7_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(value);

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for a two-digit common-anode
// seven-segment display.
//   clk, rst     : system clock, synchronous active-high reset.
//   digit0_val   : hex value for the right digit.
//   digit1_val   : hex value for the left digit.
//   digit_en     : bit0 enables the right digit, bit1 the left digit.
//   a0, a1       : right/left anode, active-low, registered.
//   cathode      : segments {a..g}, active-low, registered.
//   frame_tick   : one-cycle pulse when a full two-digit scan completes.
//   dbg_state    : current scan FSM state (seg_pkg::scan_state_t encoding).
//   dbg_count    : current slot counter value.
//
// Each digit owns a slot of REFRESH_DIV cycles: SHOW for
// REFRESH_DIV-BLANK_CYCLES cycles, then BLANK for BLANK_CYCLES cycles.
// The outputs are registered from the FSM position, so they trail
// dbg_state/dbg_count by one cycle; anode and cathode always update on the
// same edge.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    digit0_val,
  input  logic [3:0]    digit1_val,
  input  logic [1:0]    digit_en,
  output logic          a0,
  output logic          a1,
  output logic [6:0]    cathode,
  output logic          frame_tick,
  output logic [1:0]    dbg_state,
  output logic [CW-1:0] dbg_count
);

  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - BLANK_CYCLES - 1);

  scan_state_t   state;
  logic [CW-1:0] cnt;
  logic [3:0]    val_q;
  logic          en_q;

  logic          entry;
  logic [3:0]    cur_val;
  logic          cur_en;
  logic [6:0]    dec_seg;

  // The first cycle of a SHOW state is the slot entry: the digit inputs are
  // captured there and used straight away, so the lit digit never shows the
  // previous slot's value.
  assign entry = ((state == SHOW0) || (state == SHOW1)) && (cnt == '0);

  always_comb begin
    cur_val = val_q;
    cur_en  = en_q;
    if (entry) begin
      if (state == SHOW0) begin
        cur_val = digit0_val;
        cur_en  = digit_en[0];
      end else begin
        cur_val = digit1_val;
        cur_en  = digit_en[1];
      end
    end
  end

  seg7_hex_decode u_decode (
    .value (cur_val),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SHOW0;
      cnt        <= '0;
      val_q      <= '0;
      en_q       <= 1'b0;
      a0         <= 1'b1;
      a1         <= 1'b1;
      cathode    <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;

      if (entry) begin
        val_q <= cur_val;
        en_q  <= cur_en;
      end

      // Slot counter is a plain clock enable for the FSM; it wraps with no
      // idle cycle so the scan period is exactly 2*REFRESH_DIV.
      if (cnt == CNT_LAST) cnt <= '0;
      else                 cnt <= cnt + CW'(1);

      case (state)
        SHOW0:  if (cnt == SHOW_LAST) state <= BLANK0;
        BLANK0: if (cnt == CNT_LAST)  state <= SHOW1;
        SHOW1:  if (cnt == SHOW_LAST) state <= BLANK1;
        BLANK1: if (cnt == CNT_LAST) begin
          state      <= SHOW0;
          frame_tick <= 1'b1;
        end
      endcase

      // Default everything dark; at most one SHOW branch can light an anode,
      // so both anodes can never be low together.
      a0      <= 1'b1;
      a1      <= 1'b1;
      cathode <= SEG_BLANK;
      if ((state == SHOW0) && cur_en) begin
        a0      <= 1'b0;
        cathode <= dec_seg;
      end
      if ((state == SHOW1) && cur_en) begin
        a1      <= 1'b0;
        cathode <= dec_seg;
      end
    end
  end

  assign dbg_state = state;
  assign dbg_count = cnt;

endmodule
